sm83_ext_bus_responder: RTL and testbench
=========================================

Name: sm83_ext_bus_responder

Overview:
- Target-side endpoint of the SM83 core's external bus: consumes the core address bus A[15:0] with RD/WR strobes and returns read data for the core to place on its internal DL bus.
- Decodes each access into one of three regions:
  - HRAM, served internally with zero wait states;
  - unmapped I/O hole, which reads as open bus;
  - a backing memory port with a req/ack handshake and a timeout.
- Sits between the core top level and the system memory model / MMIO fabric.

Parameters:
- HRAM_BASE, 16'hFF80, first HRAM address; HRAM covers HRAM_BASE..16'hFFFE (127 bytes).
- TIMEOUT, 8, max CLK cycles waiting for MEM_ACK before the access is aborted.
- OPEN_BUS, 8'hFF, value returned for unmapped reads and timeouts.

Ports:
- CLK  input  1  single system clock, all state on rising edge.
- SYNC_RES  input  1  synchronous reset, active-high.
- A  input  16  core external address bus.
- RD  input  1  core read strobe, level, held for the whole access.
- WR  input  1  core write strobe, level, held for the whole access.
- DOUT  input  8  write data from core (DL side).
- DIN  output  8  read data to core.
- D_OE  output  1  1: DIN valid and driven toward the core.
- READY  output  1  1: current access complete.
- MEM_REQ  output  1  backing-port request, held until ack.
- MEM_WE  output  1  backing-port write enable, qualified by MEM_REQ.
- MEM_ADDR  output  16  backing-port address.
- MEM_WDATA  output  8  backing-port write data.
- MEM_RDATA  input  8  backing-port read data, valid with MEM_ACK.
- MEM_ACK  input  1  backing-port completion, one-cycle pulse.
- ERR  output  1  sticky error flag, cleared only by SYNC_RES.

Behaviour:
- Reset (SYNC_RES=1 at an edge): state=IDLE, DIN=8'h00, D_OE=0, READY=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, ERR=0.
- Reset mid-access drops MEM_REQ in the same edge. A late MEM_ACK is then ignored.
- SYNC_RES overrides all other inputs.
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Strobe sampling: on each edge in IDLE:
  - RD^WR=1 starts an access. A and DOUT are latched into addr_q / wdata_q.
  - RD&WR=1: no access starts, ERR is set, state stays IDLE.
- Region decode uses addr_q:
  - HRAM: addr_q in HRAM_BASE..16'hFFFE.
  - HOLE: 16'hFEA0..16'hFEFF.
  - MEM: all other addresses.
- States:
  - IDLE: waits for a strobe as above.
  - HRAM: read latches hram[addr_q-HRAM_BASE] into DIN; write stores wdata_q. Next state DONE, so latency is 2 edges from strobe to READY.
  - HOLE: read sets DIN=OPEN_BUS; write is discarded. Next state DONE.
  - MREQ: MEM_REQ=1, MEM_ADDR=addr_q, MEM_WE=WR, MEM_WDATA=wdata_q. The wait counter starts at 0 and increments each cycle.
    - MEM_ACK=1: for a read, DIN=MEM_RDATA. Go to DONE. MEM_REQ drops on the same edge.
    - Counter reaching TIMEOUT-1 without ack: DIN=OPEN_BUS, ERR=1, MEM_REQ drops, go to DONE.
    - MEM_ACK on the final count cycle wins over the timeout.
  - DONE: READY=1; D_OE=1 for reads only. Held while the initiating strobe stays asserted. When the strobe deasserts, the next edge returns to IDLE, with READY=0 and D_OE=0 there.
- A new strobe is accepted only in IDLE, so back-to-back accesses need at least one strobe-low cycle.
- A and DOUT changes after latch are ignored. The latched address is not re-decoded.
- Counter width: $clog2(TIMEOUT+1). TIMEOUT=0 is illegal and must be caught by an elaboration check.

Optional Feature:
- Macro SM83_ECHO_RAM_EN.
- Defined: accesses to 16'hE000..16'hFDFF are forwarded on MEM_ADDR as addr_q-16'h2000, so echo RAM aliases C000..DDFF.
- Undefined: those addresses pass to MEM_ADDR unchanged.

Decomposition:
- Package sm83_bus_pkg:
  - state enum (IDLE, HRAM, HOLE, MREQ, DONE);
  - region enum;
  - constants HOLE_LO=16'hFEA0, HOLE_HI=16'hFEFF, ECHO_LO=16'hE000, ECHO_HI=16'hFDFF, ECHO_OFS=16'h2000.
- One sub-module sm83_hram: 127x8 synchronous single-port array with we/addr/wdata/rdata, 1-cycle read.

Test Plan:
- HRAM round trip: WR A=FF80 DOUT=5A, then RD A=FF80 -> DIN=5A with D_OE=1 and READY two edges after RD rises; MEM_REQ never asserted.
- Hole read: RD A=FEA5 -> DIN=FF, READY=1, ERR=0, no MEM_REQ.
- MEM read with wait: RD A=C123, MEM_ACK after 3 cycles with MEM_RDATA=A7 -> MEM_ADDR=C123, MEM_WE=0, DIN=A7, MEM_REQ low the cycle after ack.
- Timeout: RD A=4000, no ack, TIMEOUT=8 -> MEM_REQ high exactly 8 cycles, DIN=FF, ERR=1 stays set until SYNC_RES.
- Conflict and reset: RD=WR=1 -> ERR=1, no access. SYNC_RES during MREQ -> MEM_REQ=0 next edge, all outputs at reset values, late MEM_ACK ignored.
- Echo (macro defined): WR A=E010 DOUT=33 -> MEM_ADDR=C010, MEM_WE=1, MEM_WDATA=33. Macro undefined: MEM_ADDR=E010.

Source files
------------

// File: rtl/sm83_ext_bus_responder_pkg.sv
// Shared types and address-map constants for the SM83 external bus responder.
// Holds the FSM states, the region enum and the region decoder.
package sm83_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HRAM,
    HOLE,
    MREQ,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RG_HRAM,
    RG_HOLE,
    RG_MEM
  } region_e;

  localparam logic [15:0] HOLE_LO  = 16'hFEA0;
  localparam logic [15:0] HOLE_HI  = 16'hFEFF;
  localparam logic [15:0] ECHO_LO  = 16'hE000;
  localparam logic [15:0] ECHO_HI  = 16'hFDFF;
  localparam logic [15:0] ECHO_OFS = 16'h2000;
  localparam logic [15:0] HRAM_HI  = 16'hFFFE;

  function automatic region_e region_of(
    input logic [15:0] a,
    input logic [15:0] base
  );
    region_e r;
    unique case (1'b1)
      (a >= base && a <= HRAM_HI):    r = RG_HRAM;
      (a >= HOLE_LO && a <= HOLE_HI): r = RG_HOLE;
      default:                        r = RG_MEM;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sm83_ext_bus_responder_if.sv
// Core-side strobes plus backing-memory port of the SM83 external bus.
// master drives address/strobes and memory responses; slave is the responder.
interface sm83_ext_bus_if;
  logic [15:0] A;
  logic        RD;
  logic        WR;
  logic [7:0]  DOUT;
  logic [7:0]  DIN;
  logic        D_OE;
  logic        READY;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;
  logic        MEM_ACK;
  logic        ERR;

  modport master (
    output A, RD, WR, DOUT, MEM_RDATA, MEM_ACK,
    input  DIN, D_OE, READY, MEM_REQ, MEM_WE,
    input  MEM_ADDR, MEM_WDATA, ERR
  );

  modport slave (
    input  A, RD, WR, DOUT, MEM_RDATA, MEM_ACK,
    output DIN, D_OE, READY, MEM_REQ, MEM_WE,
    output MEM_ADDR, MEM_WDATA, ERR
  );
endinterface

// File: rtl/sm83_ext_bus_responder_hram.sv
// 127x8 single-port HRAM with registered read (one cycle latency).
// Index 127 (address FFFF) is not part of the array and is ignored.
module sm83_hram (
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] mem_q [127];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (addr != 7'd127) begin
      if (we) mem_q[addr] <= wdata;
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sm83_ext_bus_responder.sv
// SM83 external bus target: HRAM, open-bus hole, and a req/ack memory port.
// Define SM83_ECHO_RAM_EN to fold E000..FDFF onto C000..DDFF on MEM_ADDR.
module sm83_ext_bus_responder
  import sm83_bus_pkg::*;
#(
  parameter logic [15:0] HRAM_BASE = 16'hFF80,
  parameter int          TIMEOUT   = 8,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input logic CLK,
  input logic SYNC_RES,
  sm83_ext_bus_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_e        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    din_q, din_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe;
  region_e       rg;
  logic [6:0]    hram_idx;
  logic [7:0]    hram_rdata;
  logic          hram_we;
  logic [15:0]   mem_addr;

  assign rg = region_of(bus.A, HRAM_BASE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    rd_d    = rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    strobe  = rd_q ? bus.RD : bus.WR;
    case (state_q)
      IDLE: begin
        if (bus.RD && bus.WR) begin
          err_d = 1'b1;
        end else if (bus.RD ^ bus.WR) begin
          addr_d  = bus.A;
          wdata_d = bus.DOUT;
          rd_d    = bus.RD;
          cnt_d   = '0;
          unique case (rg)
            RG_HRAM: state_d = HRAM;
            RG_HOLE: state_d = HOLE;
            default: state_d = MREQ;
          endcase
        end
      end
      HRAM: begin
        if (rd_q) din_d = hram_rdata;
        state_d = DONE;
      end
      HOLE: begin
        if (rd_q) din_d = OPEN_BUS;
        state_d = DONE;
      end
      MREQ: begin
        // ack on the last count cycle still wins
        if (bus.MEM_ACK) begin
          if (rd_q) din_d = bus.MEM_RDATA;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          din_d   = OPEN_BUS;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!strobe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // addr_d is the incoming address in IDLE, so the read lands by HRAM state
  assign hram_idx = 7'(addr_d - HRAM_BASE);
  assign hram_we  = (state_q == HRAM) && !rd_q;

  sm83_hram u_hram (
    .clk   (CLK),
    .we    (hram_we),
    .addr  (hram_idx),
    .wdata (wdata_q),
    .rdata (hram_rdata)
  );

`ifdef SM83_ECHO_RAM_EN
  assign mem_addr = (addr_q >= ECHO_LO && addr_q <= ECHO_HI) ?
                    addr_q - ECHO_OFS : addr_q;
`else
  assign mem_addr = addr_q;
`endif

  assign bus.DIN       = din_q;
  assign bus.READY     = (state_q == DONE);
  assign bus.D_OE      = (state_q == DONE) && rd_q;
  assign bus.MEM_REQ   = (state_q == MREQ);
  assign bus.MEM_WE    = (state_q == MREQ) && !rd_q;
  assign bus.MEM_ADDR  = mem_addr;
  assign bus.MEM_WDATA = wdata_q;
  assign bus.ERR       = err_q;
endmodule

// File: tb/tb_sm83_ext_bus_responder.sv
// Randomized bench for sm83_ext_bus_responder with a transaction-level model.
// Directed literal checks pin the model; a negedge process compares every cycle.
module tb_sm83_ext_bus_responder;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm83_ext_bus_if bus ();

  sm83_ext_bus_responder #(
    .HRAM_BASE (16'hFF80),
    .TIMEOUT   (TO),
    .OPEN_BUS  (8'hFF)
  ) dut (
    .CLK      (clk),
    .SYNC_RES (rst),
    .bus      (bus)
  );

  int nvec = 0;
  int nfail = 0;
  int req_cnt = 0;
  bit chk_en = 1'b0;

  logic        exp_ready, exp_doe, exp_req, exp_we, exp_err;
  logic [7:0]  exp_din, exp_wdata;
  logic [15:0] exp_addr;
  logic [7:0]  hram_m [127];

  logic [7:0]  obs_din, obs_wdata;
  logic [15:0] obs_addr;
  logic        obs_ready, obs_doe, obs_we;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] map_addr(input logic [15:0] a);
`ifdef SM83_ECHO_RAM_EN
    if (a >= 16'hE000 && a <= 16'hFDFF) return a - 16'h2000;
`endif
    return a;
  endfunction

  always @(negedge clk) begin
    if (bus.MEM_REQ === 1'b1) req_cnt++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(bus.READY), 32'(exp_ready));
      check("d_oe", 32'(bus.D_OE), 32'(exp_doe));
      check("mem_req", 32'(bus.MEM_REQ), 32'(exp_req));
      check("err", 32'(bus.ERR), 32'(exp_err));
      if (exp_doe) check("din", 32'(bus.DIN), 32'(exp_din));
      if (exp_req) begin
        check("mem_addr", 32'(bus.MEM_ADDR), 32'(exp_addr));
        check("mem_we", 32'(bus.MEM_WE), 32'(exp_we));
        if (exp_we) check("mem_wdata", 32'(bus.MEM_WDATA), 32'(exp_wdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ack_at: cycle index of MEM_REQ in which MEM_ACK pulses (>= TO: none)
  task automatic access(input bit rd, input logic [15:0] a,
                        input logic [7:0] d, input int ack_at,
                        input logic [7:0] rdat, input int hold);
    bit hit;
    req_cnt = 0;
    bus.A = a;
    bus.DOUT = d;
    bus.RD = rd;
    bus.WR = !rd;
    tick();
    bus.A = 16'($urandom);
    bus.DOUT = 8'($urandom);
    if (a >= 16'hFF80 && a != 16'hFFFF) begin
      tick();
      if (rd) exp_din = hram_m[7'(a - 16'hFF80)];
      else hram_m[7'(a - 16'hFF80)] = d;
    end else if (a >= 16'hFEA0 && a <= 16'hFEFF) begin
      tick();
      if (rd) exp_din = 8'hFF;
    end else begin
      exp_req = 1'b1;
      exp_we = !rd;
      exp_addr = map_addr(a);
      exp_wdata = d;
      @(negedge clk);
      obs_addr = bus.MEM_ADDR;
      obs_we = bus.MEM_WE;
      obs_wdata = bus.MEM_WDATA;
      hit = 1'b0;
      for (int c = 0; c < TO; c++) begin
        if (c == ack_at) begin
          bus.MEM_ACK = 1'b1;
          bus.MEM_RDATA = rdat;
        end
        tick();
        bus.MEM_ACK = 1'b0;
        bus.MEM_RDATA = 8'($urandom);
        if (c == ack_at) begin
          hit = 1'b1;
          break;
        end
      end
      exp_req = 1'b0;
      exp_we = 1'b0;
      if (hit) begin
        if (rd) exp_din = rdat;
      end else begin
        exp_din = 8'hFF;
        exp_err = 1'b1;
      end
    end
    exp_ready = 1'b1;
    exp_doe = rd;
    @(negedge clk);
    obs_din = bus.DIN;
    obs_ready = bus.READY;
    obs_doe = bus.D_OE;
    repeat (hold) tick();
    bus.RD = 1'b0;
    bus.WR = 1'b0;
    tick();
    exp_ready = 1'b0;
    exp_doe = 1'b0;
  endtask

  task automatic conflict();
    req_cnt = 0;
    bus.A = 16'($urandom);
    bus.RD = 1'b1;
    bus.WR = 1'b1;
    tick();
    exp_err = 1'b1;
    bus.RD = 1'b0;
    bus.WR = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.RD = 1'b0;
    bus.WR = 1'b0;
    tick();
    exp_ready = 1'b0;
    exp_doe = 1'b0;
    exp_req = 1'b0;
    exp_we = 1'b0;
    exp_err = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] echo_exp;
    int sel;
    bus.A = '0;
    bus.RD = 1'b0;
    bus.WR = 1'b0;
    bus.DOUT = '0;
    bus.MEM_RDATA = '0;
    bus.MEM_ACK = 1'b0;
    rst = 1'b1;
    exp_ready = 1'b0;
    exp_doe = 1'b0;
    exp_req = 1'b0;
    exp_we = 1'b0;
    exp_err = 1'b0;
    exp_din = '0;
    exp_wdata = '0;
    exp_addr = '0;
    tick();
    tick();
    check("rst_din", 32'(bus.DIN), 32'h00);
    check("rst_d_oe", 32'(bus.D_OE), 32'h0);
    check("rst_ready", 32'(bus.READY), 32'h0);
    check("rst_mem_req", 32'(bus.MEM_REQ), 32'h0);
    check("rst_mem_we", 32'(bus.MEM_WE), 32'h0);
    check("rst_mem_addr", 32'(bus.MEM_ADDR), 32'h0);
    check("rst_mem_wdata", 32'(bus.MEM_WDATA), 32'h0);
    check("rst_err", 32'(bus.ERR), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 127; i++)
      access(1'b0, 16'hFF80 + 16'(i), 8'($urandom), 0, 8'h00,
             $urandom_range(0, 1));

    access(1'b0, 16'hFF80, 8'h5A, 0, 8'h00, 0);
    check("hram_wr_noreq", 32'(req_cnt), 32'd0);
    access(1'b1, 16'hFF80, 8'h00, 0, 8'h00, 1);
    check("hram_rd_din", 32'(obs_din), 32'h5A);
    check("hram_rd_ready", 32'(obs_ready), 32'h1);
    check("hram_rd_doe", 32'(obs_doe), 32'h1);
    check("hram_rd_noreq", 32'(req_cnt), 32'd0);

    access(1'b1, 16'hFEA5, 8'h00, 0, 8'h00, 0);
    check("hole_din", 32'(obs_din), 32'hFF);
    check("hole_ready", 32'(obs_ready), 32'h1);
    check("hole_err", 32'(bus.ERR), 32'h0);
    check("hole_noreq", 32'(req_cnt), 32'd0);

    access(1'b1, 16'hC123, 8'h00, 3, 8'hA7, 0);
    check("mem_rd_addr", 32'(obs_addr), 32'hC123);
    check("mem_rd_we", 32'(obs_we), 32'h0);
    check("mem_rd_din", 32'(obs_din), 32'hA7);
    check("mem_rd_req_cycles", 32'(req_cnt), 32'd4);

`ifdef SM83_ECHO_RAM_EN
    echo_exp = 16'hC010;
`else
    echo_exp = 16'hE010;
`endif
    access(1'b0, 16'hE010, 8'h33, 1, 8'h00, 0);
    check("echo_addr", 32'(obs_addr), 32'(echo_exp));
    check("echo_we", 32'(obs_we), 32'h1);
    check("echo_wdata", 32'(obs_wdata), 32'h33);

    access(1'b1, 16'h4000, 8'h00, -1, 8'h00, 0);
    check("to_req_cycles", 32'(req_cnt), 32'd8);
    check("to_din", 32'(obs_din), 32'hFF);
    check("to_err", 32'(bus.ERR), 32'h1);
    access(1'b1, 16'hFEB0, 8'h00, 0, 8'h00, 0);
    check("to_err_sticky", 32'(bus.ERR), 32'h1);

    req_cnt = 0;
    bus.A = 16'h4000;
    bus.RD = 1'b1;
    bus.WR = 1'b0;
    tick();
    exp_req = 1'b1;
    exp_we = 1'b0;
    exp_addr = 16'h4000;
    tick();
    tick();
    do_reset();
    check("midrst_req", 32'(bus.MEM_REQ), 32'h0);
    check("midrst_din", 32'(bus.DIN), 32'h00);
    check("midrst_addr", 32'(bus.MEM_ADDR), 32'h0);
    check("midrst_err", 32'(bus.ERR), 32'h0);
    bus.MEM_ACK = 1'b1;
    bus.MEM_RDATA = 8'h99;
    tick();
    bus.MEM_ACK = 1'b0;
    tick();
    check("late_ack_ready", 32'(bus.READY), 32'h0);
    check("late_ack_doe", 32'(bus.D_OE), 32'h0);
    check("late_ack_din", 32'(bus.DIN), 32'h00);

    conflict();
    check("conf_err", 32'(bus.ERR), 32'h1);
    check("conf_ready", 32'(bus.READY), 32'h0);
    check("conf_noreq", 32'(req_cnt), 32'd0);
    do_reset();

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 19);
      case (sel % 5)
        0: a = 16'hFF80 + 16'($urandom_range(0, 126));
        1: a = 16'hFEA0 + 16'($urandom_range(0, 95));
        2: a = 16'hE000 + 16'($urandom_range(0, 16'h1DFF));
        3: begin
          case ($urandom_range(0, 3))
            0: a = 16'hFFFF;
            1: a = 16'hFE9F;
            2: a = 16'hFF00 + 16'($urandom_range(0, 127));
            default: a = 16'hDFFF + 16'($urandom_range(0, 1));
          endcase
        end
        default: a = 16'($urandom);
      endcase
      if (sel == 19) conflict();
      else access(1'($urandom), a, 8'($urandom), $urandom_range(0, 10),
                  8'($urandom), $urandom_range(0, 2));
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
